// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: a core port and an external (optionally locking) port share one RAM with 1-cycle read latency.
// Zero-latency grant; read data returns the next cycle; a refused side is held off (mem_hold) or simply not acked.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [3:0]  core_en,
  input  logic        core_wea,
  input  logic        core_rea,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_din,
  output logic [31:0] core_dout,
  output logic        mem_hold,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic        ext_wea,
  input  logic [3:0]  ext_be,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_din,
  output logic        ext_ack,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [3:0]  ram_en,
  output logic        ram_wea,
  output logic        ram_rea,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic {SHARED, EXT_LOCKED} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_CORE, TAG_EXT} tag_t;

  state_t        state_q, state_d;
  tag_t          tag_q, tag_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          core_req, locked, grant_core, grant_ext;

  assign core_req = (|core_en) & (core_wea | core_rea);
  // The cycle ext_lock drops is already arbitrated as SHARED.
  assign locked   = (state_q == EXT_LOCKED) && ext_lock;

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q  <= SHARED;
      tag_q    <= TAG_NONE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = TAG_NONE;
    starve_d   = starve_q;
    grant_core = 1'b0;
    grant_ext  = 1'b0;
    if (!Rst) begin
      if (locked) begin
        grant_ext = ext_req;
      end else if (ext_req && (!core_req || starve_q == STARVE_LIM)) begin
        grant_ext = 1'b1;
      end else if (core_req) begin
        grant_core = 1'b1;
      end

      if (grant_ext || !ext_req) begin
        starve_d = '0;
      end else if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + 1'b1;
      end

      state_d = ((grant_ext && ext_lock) || locked) ? EXT_LOCKED : SHARED;

      if (grant_core && core_rea && !core_wea) begin
        tag_d = TAG_CORE;
      end else if (grant_ext && !ext_wea) begin
        tag_d = TAG_EXT;
      end
    end
  end

  always_comb begin
    ram_en   = 4'h0;
    ram_wea  = 1'b0;
    ram_rea  = 1'b0;
    ram_addr = 32'h0;
    ram_din  = 32'h0;
    if (grant_ext) begin
      ram_en   = ext_be;
      ram_wea  = ext_wea;
      ram_rea  = !ext_wea;
      ram_addr = ext_addr;
      ram_din  = ext_din;
    end else if (grant_core) begin
      ram_en   = core_en;
      ram_wea  = core_wea;
      ram_rea  = core_rea;
      ram_addr = core_addr;
      ram_din  = core_din;
    end
  end

  assign ext_ack    = grant_ext;
  assign mem_hold   = core_req && !grant_core && !Rst;
  // Gating by Rst drops a read that was issued just before reset.
  assign core_dout  = (!Rst && tag_q == TAG_CORE) ? ram_dout : 32'h0;
  assign ext_rvalid = !Rst && tag_q == TAG_EXT;
  assign ext_rdata  = ext_rvalid ? ram_dout : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: RAM read data is driven by the bench per vector.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        Rst;
  logic [3:0]  core_en;
  logic        core_wea, core_rea;
  logic [31:0] core_addr, core_din, core_dout;
  logic        mem_hold;
  logic        ext_req, ext_lock, ext_wea;
  logic [3:0]  ext_be;
  logic [31:0] ext_addr, ext_din;
  logic        ext_ack, ext_rvalid;
  logic [31:0] ext_rdata;
  logic [3:0]  ram_en;
  logic        ram_wea, ram_rea;
  logic [31:0] ram_addr, ram_din, ram_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .Rst(Rst),
    .core_en(core_en), .core_wea(core_wea), .core_rea(core_rea),
    .core_addr(core_addr), .core_din(core_din),
    .core_dout(core_dout), .mem_hold(mem_hold),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_wea(ext_wea),
    .ext_be(ext_be), .ext_addr(ext_addr), .ext_din(ext_din),
    .ext_ack(ext_ack), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_en(ram_en), .ram_wea(ram_wea), .ram_rea(ram_rea),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic core_idle();
    core_en = 4'h0; core_wea = 1'b0; core_rea = 1'b0; core_addr = 32'h0; core_din = 32'h0;
  endtask

  task automatic core_set(input logic wea, input logic rea, input logic [31:0] addr);
    core_en = 4'hF; core_wea = wea; core_rea = rea; core_addr = addr; core_din = 32'hC0DE0000;
  endtask

  task automatic ext_idle();
    ext_req = 1'b0; ext_lock = 1'b0; ext_wea = 1'b0; ext_be = 4'h0; ext_addr = 32'h0; ext_din = 32'h0;
  endtask

  task automatic ext_set(input logic lock, input logic wea, input logic [31:0] addr);
    ext_req = 1'b1; ext_lock = lock; ext_wea = wea; ext_be = 4'hF; ext_addr = addr; ext_din = 32'hE0E00000;
  endtask

  initial begin
    Rst = 1'b1;
    core_idle();
    ext_idle();
    ram_dout = 32'h0;

    // Reset with both sides requesting: everything quiet.
    tick();
    core_set(1'b0, 1'b1, 32'h10);
    ext_set(1'b0, 1'b0, 32'h20);
    ram_dout = 32'hFFFF0000;
    settle();
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_rea", ram_rea, 0);
    chk("rst_ram_wea", ram_wea, 0);
    chk("rst_ext_ack", ext_ack, 0);
    chk("rst_mem_hold", mem_hold, 0);
    chk("rst_core_dout", core_dout, 0);
    chk("rst_ext_rvalid", ext_rvalid, 0);
    chk("rst_ext_rdata", ext_rdata, 0);

    // Core-only read.
    tick();
    Rst = 1'b0;
    ext_idle();
    core_set(1'b0, 1'b1, 32'h100);
    settle();
    chk("crd_ram_addr", ram_addr, 32'h100);
    chk("crd_ram_rea", ram_rea, 1);
    chk("crd_ram_en", ram_en, 4'hF);
    chk("crd_hold0", mem_hold, 0);
    tick();
    core_idle();
    ram_dout = 32'hDEADBEEF;
    settle();
    chk("crd_dout", core_dout, 32'hDEADBEEF);
    chk("crd_hold1", mem_hold, 0);
    chk("crd_no_rvalid", ext_rvalid, 0);
    tick();
    settle();
    chk("crd_dout_clear", core_dout, 0);

    // Both requesting continuously: ext wins every fifth cycle.
    tick();
    ram_dout = 32'h0;
    core_set(1'b0, 1'b1, 32'h10);
    ext_set(1'b0, 1'b1, 32'h80);
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("starve_ack_c%0d", c), ext_ack, (c % 5 == 4));
      chk($sformatf("starve_hold_c%0d", c), mem_hold, (c % 5 == 4));
      chk($sformatf("starve_addr_c%0d", c), ram_addr, (c % 5 == 4) ? 32'h80 : 32'h10);
      tick();
    end
    core_idle();
    ext_idle();
    settle();
    chk("starve_ext_rvalid", ext_rvalid, 0);

    // Locked ext write burst after starvation, core writing throughout.
    tick();
    core_set(1'b1, 1'b0, 32'h300);
    ext_set(1'b1, 1'b1, 32'h200);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("lock_pre_ack_c%0d", c), ext_ack, 0);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      ext_addr = 32'h200 + 32'(4 * c);
      settle();
      chk($sformatf("lock_ack_%0d", c), ext_ack, 1);
      chk($sformatf("lock_addr_%0d", c), ram_addr, 32'h200 + 32'(4 * c));
      chk($sformatf("lock_hold_%0d", c), mem_hold, 1);
      chk($sformatf("lock_rvalid_%0d", c), ext_rvalid, 0);
      tick();
    end
    ext_lock = 1'b0;
    ext_addr = 32'h20C;
    settle();
    chk("unlock_ack", ext_ack, 0);
    chk("unlock_addr", ram_addr, 32'h300);
    chk("unlock_hold", mem_hold, 0);
    chk("unlock_rvalid", ext_rvalid, 0);
    tick();
    core_idle();
    ext_idle();

    // Ext read then core read back to back.
    tick();
    ext_set(1'b0, 1'b0, 32'h40);
    settle();
    chk("b2b_ext_ack", ext_ack, 1);
    chk("b2b_ext_addr", ram_addr, 32'h40);
    chk("b2b_ext_rea", ram_rea, 1);
    tick();
    ext_idle();
    core_set(1'b0, 1'b1, 32'h44);
    ram_dout = 32'h11112222;
    settle();
    chk("b2b_rvalid1", ext_rvalid, 1);
    chk("b2b_rdata1", ext_rdata, 32'h11112222);
    chk("b2b_core_addr", ram_addr, 32'h44);
    chk("b2b_core_dout1", core_dout, 0);
    tick();
    core_idle();
    ram_dout = 32'h33334444;
    settle();
    chk("b2b_core_dout2", core_dout, 32'h33334444);
    chk("b2b_rvalid2", ext_rvalid, 0);
    chk("b2b_rdata2", ext_rdata, 0);

    // Reset right after a locked ext read.
    tick();
    ext_set(1'b1, 1'b0, 32'h60);
    settle();
    chk("mid_lock_ack", ext_ack, 1);
    tick();
    Rst = 1'b1;
    core_set(1'b0, 1'b1, 32'h500);
    ram_dout = 32'h55555555;
    settle();
    chk("mid_rst_rvalid", ext_rvalid, 0);
    chk("mid_rst_rdata", ext_rdata, 0);
    chk("mid_rst_ack", ext_ack, 0);
    chk("mid_rst_ram_en", ram_en, 0);
    chk("mid_rst_hold", mem_hold, 0);
    chk("mid_rst_core_dout", core_dout, 0);
    tick();
    Rst = 1'b0;
    settle();
    chk("post_rst_addr", ram_addr, 32'h500);
    chk("post_rst_hold", mem_hold, 0);
    chk("post_rst_ack", ext_ack, 0);
    chk("post_rst_rvalid", ext_rvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
